redun_carry_resolve: RTL and testbench

- Sequential carry-resolution engine for redundant-form operands: WRD_BITS+1-bit digits, each with one carry bit.
- Normalises an operand to canonical digits (carry bits zero), WRDS_PER_CYC digits per cycle. This trades latency for a short carry chain.
- Two modes: full resolve (carry-out exported), or boundary equalize (lower BOUNDARY digits resolved, carry folded into digit BOUNDARY).
- Sits between the Montgomery multiplier datapath and the MSU output/compare logic. Also flags speculative top-word carries.

---
 rtl/redun_carry_resolve.sv | 172 +++++++++++++++++
 tb/tb_redun_carry_resolve.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/redun_carry_resolve.sv
// Sequential carry-resolution engine for redundant-form operands.
// Each stored digit is WRD_BITS+1 bits wide: a canonical WRD_BITS-bit value
// plus one pending carry bit. The engine resolves WRDS_PER_CYC digits per
// cycle. Full mode normalises every digit and exports the final carry.
// Boundary mode normalises the lower BOUNDARY digits and folds the carry
// into digit BOUNDARY.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_dat, i_mode       operand (digit k at [k*(WRD_BITS+1) +: WRD_BITS+1]),
//                       0 = full resolve, 1 = boundary equalize
//   i_val, o_rdy        input handshake
//   o_dat               result, same packing as i_dat
//   o_cout              final carry (full mode only)
//   o_ovf               boundary fold wrapped digit BOUNDARY
//   o_spec              a top-window digit is all ones (speculative carry)
//   o_val, i_rdy        output handshake
module redun_carry_resolve #(
   parameter int unsigned WRD_BITS     = 16,
   parameter int unsigned NUM_WRDS     = 65,
   parameter int unsigned WRDS_PER_CYC = 8,
   parameter int unsigned BOUNDARY     = 32,
   parameter int unsigned SPEC_WRDS    = 2
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
   input  logic                             i_mode,
   input  logic                             i_val,
   output logic                             o_rdy,
   output logic [NUM_WRDS*(WRD_BITS+1)-1:0] o_dat,
   output logic [1:0]                       o_cout,
   output logic                             o_ovf,
   output logic                             o_spec,
   output logic                             o_val,
   input  logic                             i_rdy
);

   localparam int unsigned DW    = WRD_BITS + 1;
   localparam int unsigned SW    = WRD_BITS + 2;
   localparam int unsigned KW    = $clog2(NUM_WRDS);
   localparam int unsigned IDX_W = $clog2(NUM_WRDS + WRDS_PER_CYC + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [DW-1:0]      dat_q   [NUM_WRDS];
   logic [DW-1:0]      in_dig  [NUM_WRDS];
   logic [DW-1:0]      nxt_dat [NUM_WRDS];
   logic [IDX_W-1:0]   idx_q;
   logic [1:0]         carry_q;
   logic               mode_q;
   logic               ovf_q;

   logic [1:0]         chain_c;
   logic [SW-1:0]      sum_c;
   logic [DW:0]        fold_c;
   logic               last_c;
   logic               fold_ovf_c;
   logic               spec_c;
   int unsigned        lim_c;
   int unsigned        k_c;
   logic [NUM_WRDS*DW-1:0] pack_c;

   // Unpack the operand and pack the working digits for the result port
   always_comb begin
      pack_c = '0;
      for (int unsigned k = 0; k < NUM_WRDS; k++) begin
         in_dig[k]             = i_dat[k*DW +: DW];
         pack_c[k*DW +: DW]    = dat_q[k];
      end
   end

   // One RUN cycle: chained carry over this cycle's digit slice, plus the
   // boundary fold when this is the final slice in boundary mode
   always_comb begin
      nxt_dat    = dat_q;
      chain_c    = carry_q;
      sum_c      = '0;
      k_c        = 0;
      fold_c     = '0;
      fold_ovf_c = 1'b0;
      lim_c      = mode_q ? BOUNDARY : NUM_WRDS;
      for (int unsigned j = 0; j < WRDS_PER_CYC; j++) begin
         k_c = int'(idx_q) + j;
         if (k_c < lim_c) begin
            sum_c            = {1'b0, dat_q[KW'(k_c)]} + SW'(chain_c);
            nxt_dat[KW'(k_c)] = {1'b0, sum_c[WRD_BITS-1:0]};
            chain_c          = sum_c[SW-1:WRD_BITS];
         end
      end
      last_c = (int'(idx_q) + WRDS_PER_CYC) >= lim_c;
      if (last_c && mode_q) begin
         fold_c            = (DW+1)'(dat_q[BOUNDARY]) + (DW+1)'(chain_c);
         nxt_dat[BOUNDARY] = fold_c[DW-1:0];
         fold_ovf_c        = fold_c[DW];
      end
   end

   // Speculative-carry detect over the top SPEC_WRDS+1 result digits
   always_comb begin
      spec_c = 1'b0;
      for (int unsigned k = NUM_WRDS - 1 - SPEC_WRDS; k < NUM_WRDS; k++) begin
         if (&dat_q[k][WRD_BITS-1:0]) spec_c = 1'b1;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         for (int unsigned k = 0; k < NUM_WRDS; k++) dat_q[k] <= '0;
         idx_q   <= '0;
         carry_q <= '0;
         mode_q  <= 1'b0;
         ovf_q   <= 1'b0;
         o_rdy   <= 1'b1;
         o_val   <= 1'b0;
         o_dat   <= '0;
         o_cout  <= '0;
         o_ovf   <= 1'b0;
         o_spec  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_val && o_rdy) begin
                  dat_q   <= in_dig;
                  mode_q  <= i_mode;
                  idx_q   <= '0;
                  carry_q <= '0;
                  ovf_q   <= 1'b0;
                  o_rdy   <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               dat_q   <= nxt_dat;
               carry_q <= chain_c;
               idx_q   <= idx_q + IDX_W'(WRDS_PER_CYC);
               if (last_c) begin
                  ovf_q   <= fold_ovf_c;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; it then holds until taken
               if (!o_val) begin
                  o_val  <= 1'b1;
                  o_dat  <= pack_c;
                  o_cout <= mode_q ? 2'd0 : carry_q;
                  o_ovf  <= mode_q ? ovf_q : 1'b0;
                  o_spec <= spec_c;
               end else if (i_rdy) begin
                  o_val   <= 1'b0;
                  o_rdy   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               o_rdy   <= 1'b1;
               o_val   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Directed bench for redun_carry_resolve with a 4-digit, 4-bit configuration.
module tb_redun_carry_resolve;

   localparam int unsigned WB  = 4;
   localparam int unsigned NW  = 4;
   localparam int unsigned DW  = WB + 1;

   logic              clk;
   logic              rst_n;
   logic [NW*DW-1:0]  i_dat;
   logic              i_mode;
   logic              i_val;
   logic              o_rdy;
   logic [NW*DW-1:0]  o_dat;
   logic [1:0]        o_cout;
   logic              o_ovf;
   logic              o_spec;
   logic              o_val;
   logic              i_rdy;

   int n_chk;
   int n_fail;

   redun_carry_resolve #(
      .WRD_BITS     (WB),
      .NUM_WRDS     (NW),
      .WRDS_PER_CYC (2),
      .BOUNDARY     (2),
      .SPEC_WRDS    (1)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_dat   (i_dat),
      .i_mode  (i_mode),
      .i_val   (i_val),
      .o_rdy   (o_rdy),
      .o_dat   (o_dat),
      .o_cout  (o_cout),
      .o_ovf   (o_ovf),
      .o_spec  (o_spec),
      .o_val   (o_val),
      .i_rdy   (i_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NW*DW-1:0] mk(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Present one operand in IDLE and return just after the accept edge
   task automatic start_op(input logic [NW*DW-1:0] dat, input logic mode);
      int guard;
      guard = 0;
      while (!o_rdy && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("rdy_before_accept", 32'(o_rdy), 32'd1);
      @(negedge clk);
      i_dat  = dat;
      i_mode = mode;
      i_val  = 1'b1;
      @(posedge clk); #1;
      i_val  = 1'b0;
      i_dat  = '0;
      check("rdy_low_after_accept", 32'(o_rdy), 32'd0);
   endtask

   // Count edges from accept to o_val, bounded
   task automatic wait_val(input int exp_lat);
      int cnt;
      cnt = 0;
      while (cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
         if (o_val) break;
      end
      check("latency", 32'(cnt), 32'(exp_lat));
   endtask

   task automatic check_res(input string tag, input logic [NW*DW-1:0] dat, input logic [1:0] cout,
                            input logic ovf, input logic spec);
      check({tag, "_dat"},  32'(o_dat),  32'(dat));
      check({tag, "_cout"}, 32'(o_cout), 32'(cout));
      check({tag, "_ovf"},  32'(o_ovf),  32'(ovf));
      check({tag, "_spec"}, 32'(o_spec), 32'(spec));
   endtask

   // With i_rdy high the result is taken on the next edge
   task automatic drain;
      @(posedge clk); #1;
      check("val_drop", 32'(o_val), 32'd0);
      check("rdy_back", 32'(o_rdy), 32'd1);
   endtask

   logic [NW*DW-1:0] t1_in, t1_out;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      i_dat  = '0;
      i_mode = 1'b0;
      i_val  = 1'b0;
      i_rdy  = 1'b1;
      t1_in  = mk(5'h1F, 5'h1F, 5'h1F, 5'h1F);
      t1_out = mk(5'h0F, 5'h00, 5'h01, 5'h01);

      #12;
      check("rst_rdy",  32'(o_rdy),  32'd1);
      check("rst_val",  32'(o_val),  32'd0);
      check("rst_dat",  32'(o_dat),  32'd0);
      check("rst_cout", 32'(o_cout), 32'd0);
      check("rst_ovf",  32'(o_ovf),  32'd0);
      check("rst_spec", 32'(o_spec), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: full mode, carries ripple through every digit
      start_op(t1_in, 1'b0);
      wait_val(3);
      check_res("t1", t1_out, 2'd2, 1'b0, 1'b0);
      drain();

      // 2: boundary mode, carry folds into digit 2, digit 3 untouched
      start_op(mk(5'h1F, 5'h1F, 5'h03, 5'h10), 1'b1);
      wait_val(2);
      check_res("t2", mk(5'h0F, 5'h00, 5'h05, 5'h10), 2'd0, 1'b0, 1'b0);
      drain();

      // 3: boundary fold wraps digit 2
      start_op(mk(5'h1F, 5'h1F, 5'h1F, 5'h00), 1'b1);
      wait_val(2);
      check_res("t3", mk(5'h0F, 5'h00, 5'h01, 5'h00), 2'd0, 1'b1, 1'b0);
      drain();

      // 4: already canonical; digit 2 all ones raises the speculative flag
      start_op(mk(5'h00, 5'h00, 5'h0F, 5'h00), 1'b0);
      wait_val(3);
      check_res("t4", mk(5'h00, 5'h00, 5'h0F, 5'h00), 2'd0, 1'b0, 1'b1);
      drain();

      // 5: backpressure with i_val pulsed in DONE
      i_rdy = 1'b0;
      start_op(t1_in, 1'b0);
      wait_val(3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_val = (i % 2) == 0;
         i_dat = mk(5'h01, 5'h02, 5'h03, 5'h04);
         @(posedge clk); #1;
         check("bp_val",  32'(o_val),  32'd1);
         check("bp_dat",  32'(o_dat),  32'(t1_out));
         check("bp_cout", 32'(o_cout), 32'd2);
         check("bp_rdy",  32'(o_rdy),  32'd0);
      end
      @(negedge clk);
      i_val = 1'b0;
      i_dat = '0;
      i_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_rdy_next", 32'(o_rdy), 32'd1);
      check("bp_val_next", 32'(o_val), 32'd0);
      @(posedge clk); #1;
      check("bp_not_accepted", 32'(o_rdy), 32'd1);

      // 6: reset mid-RUN clears outputs immediately
      start_op(mk(5'h1F, 5'h1F, 5'h1F, 5'h00), 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_val",  32'(o_val),  32'd0);
      check("mid_rst_dat",  32'(o_dat),  32'd0);
      check("mid_rst_cout", 32'(o_cout), 32'd0);
      check("mid_rst_ovf",  32'(o_ovf),  32'd0);
      check("mid_rst_spec", 32'(o_spec), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_rdy", 32'(o_rdy), 32'd1);
      check("post_rst_val", 32'(o_val), 32'd0);
      start_op(t1_in, 1'b0);
      wait_val(3);
      check_res("t6", t1_out, 2'd2, 1'b0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
